icache_sa: RTL and testbench
============================

Name: icache_sa

Overview:
- Parametrised set-associative instruction cache; successor to the 4-line direct-mapped fetch cache.
- Sits between the fetch stage and the line-based memory arbiter.
- Generalises line size, set count and associativity; adds replacement, explicit stall/valid handshake, flush-safe refill and hit/miss counters.

Parameters:
- ADDR_W, 32, byte address width.
- LINE_BYTES, 16, bytes per line; power of 2, ≥4.
- SETS, 4, number of sets; power of 2.
- WAYS, 2, associativity; power of 2, 1..8.
- CNT_W, 32, perf counter width.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- flush  in  1  invalidate all lines.
- cpu_req  in  1  fetch request; held with cpu_addr stable while cpu_stall=1.
- cpu_addr  in  ADDR_W  fetch byte address; bits [1:0] ignored.
- cpu_rdata  out  32  instruction word.
- cpu_valid  out  1  one-cycle pulse; cpu_rdata valid.
- cpu_stall  out  1  request not accepted this cycle.
- mem_req  out  1  line refill request; level, held until mem_ready.
- mem_addr  out  ADDR_W-OFF_W  line address (cpu_addr[ADDR_W-1:OFF_W]).
- mem_rdata  in  LINE_BYTES*8  refill line.
- mem_ready  in  1  one-cycle pulse; mem_rdata valid.
- hit_cnt  out  CNT_W  saturating hit counter.
- miss_cnt  out  CNT_W  saturating miss counter.

Behaviour:
- Address split:
  - OFF_W = log2(LINE_BYTES); IDX_W = log2(SETS).
  - Word select = addr[OFF_W-1:2].
  - Index = addr[OFF_W+IDX_W-1:OFF_W].
  - Tag = remaining upper bits.
- Reset: all valid bits 0, replacement pointers 0, state IDLE, counters 0.
  - All outputs 0 in the cycle after reset.
- FSM states: IDLE, MISS, RESP.
- IDLE:
  - cpu_req and a way matches (valid and tag equal): hit.
    - Next cycle: cpu_valid=1, cpu_rdata = word from that way.
    - cpu_stall=0 in the request cycle; hit_cnt+1.
    - Back-to-back hits sustain 1 word/cycle.
  - cpu_req and no match: cpu_stall=1 (combinational); latch index/tag/word select.
    - Choose victim way: lowest-index invalid way, else per-set round-robin pointer.
    - miss_cnt+1; go to MISS.
  - No cpu_req: cpu_valid=0.
- MISS:
  - mem_req=1, mem_addr = latched line address, cpu_stall=1.
  - On mem_ready:
    - Write mem_rdata and tag into the victim way and set valid.
    - Advance the round-robin pointer only if the victim was valid.
    - Register the requested word; go to RESP; mem_req drops the following cycle.
- RESP:
  - cpu_valid=1 with the refilled word; cpu_stall=1.
  - Return to IDLE. The CPU must drop or advance cpu_req when it sees cpu_valid.
- Flush (priority over cpu_req):
  - In IDLE: all valid bits clear at the edge; a cpu_req in the same cycle is not accepted (cpu_stall=1, no counter update).
  - In MISS: set drop flag; mem_req stays high until mem_ready. The line is not installed, no cpu_valid; return to IDLE.
  - In RESP: the response is still delivered, then all lines are invalidated.
- Boundaries:
  - mem_ready outside MISS is ignored.
  - Counters saturate at all-ones.
  - Reset mid-MISS abandons the refill; the arbiter must tolerate mem_req dropping.
  - WAYS=1 degenerates to direct-mapped; the pointer is unused.
  - Tag storage is flops, not SRAM (sets×ways ≤ 64).

Decomposition:
- Package icache_pkg:
  - Derived width functions (off_w, idx_w, tag_w).
  - State enum (IDLE/MISS/RESP).
  - Address-split struct.
- One sub-module: icache_victim_sel.
  - Per-set invalid-first / round-robin selector.
  - Inputs: valid vector, pointer. Outputs: way index, pointer update.

Test Plan (defaults):
- Cold miss: reset; cpu_req addr 0x100.
  - mem_req=1 with mem_addr=0x10 next cycle.
  - mem_ready with line {W3..W0}=0x44..,0x33..,0x22..,0x11.. → cpu_valid one cycle later, rdata=0x11...; miss_cnt=1.
- Hit after refill: addr 0x108 → cpu_valid next cycle, rdata=W2, no mem_req, hit_cnt=1.
  - Then 0x10C back-to-back → W3 one cycle later.
- Associativity: fill 0x000 and 0x040 (same set 0); both then hit.
  - 0x080 evicts way 0 (pointer=0); 0x000 misses again; 0x040 still hits.
- Flush during MISS: request 0x200; flush while mem_req=1; mem_ready arrives.
  - No cpu_valid; re-request 0x200 misses again; miss_cnt=2.
- Flush in IDLE with cpu_req 0x100 (cached):
  - cpu_stall=1 that cycle, counters unchanged.
  - Next cycle the same request misses.
- Counter saturation with CNT_W=4: 20 hits → hit_cnt holds 15.

Source files
------------

// File: rtl/icache_pkg.sv
// Shared definitions for the set-associative instruction cache.
//   - Width helpers used to derive the address split from the parameters.
//   - FSM state codes (IDLE / MISS / RESP).
// The address-split struct itself lives in icache_sa, because its field
// widths depend on that module's parameters.
package icache_pkg;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_MISS = 2'd1;
   localparam logic [1:0] S_RESP = 2'd2;

   // byte-offset bits within a line
   function automatic int off_w(input int line_bytes);
      return $clog2(line_bytes);
   endfunction

   // set-index bits (SETS >= 2)
   function automatic int idx_w(input int sets);
      return $clog2(sets);
   endfunction

   // whatever is left above offset and index
   function automatic int tag_w(input int addr_w, input int line_bytes, input int sets);
      return addr_w - $clog2(line_bytes) - $clog2(sets);
   endfunction

   // way-number bits; a direct-mapped cache still carries one bit
   function automatic int way_w(input int ways);
      return (ways > 1) ? $clog2(ways) : 1;
   endfunction

endpackage

// File: rtl/icache_sa_if.sv
// Fetch-side and memory-side handshake bundle of icache_sa.
//   slave  : the cache (takes cpu_req/cpu_addr, returns the word; issues refills)
//   master : the environment (fetch stage + line arbiter)
// cpu_req/cpu_addr     fetch request, held while cpu_stall=1
// cpu_rdata/cpu_valid  instruction word, one-cycle valid pulse
// cpu_stall            request not accepted this cycle
// mem_req/mem_addr     line refill request (level) and line address
// mem_rdata/mem_ready  refill line, one-cycle ready pulse
interface icache_sa_if #(
   parameter int ADDR_W     = 32,
   parameter int LINE_BYTES = 16
);
   import icache_pkg::*;
   localparam int OFF_W = off_w(LINE_BYTES);

   logic                      cpu_req;
   logic [ADDR_W-1:0]         cpu_addr;
   logic [31:0]               cpu_rdata;
   logic                      cpu_valid;
   logic                      cpu_stall;
   logic                      mem_req;
   logic [ADDR_W-OFF_W-1:0]   mem_addr;
   logic [LINE_BYTES*8-1:0]   mem_rdata;
   logic                      mem_ready;

   modport slave (
      input  cpu_req, cpu_addr, mem_rdata, mem_ready,
      output cpu_rdata, cpu_valid, cpu_stall, mem_req, mem_addr
   );

   modport master (
      output cpu_req, cpu_addr, mem_rdata, mem_ready,
      input  cpu_rdata, cpu_valid, cpu_stall, mem_req, mem_addr
   );

endinterface

// File: rtl/icache_victim_sel.sv
// Victim selection for one set: lowest-numbered invalid way first, otherwise
// the set's round-robin pointer.
//   valid_i   : valid bits of the set
//   ptr_i     : round-robin pointer of the set
//   way_o     : way to refill
//   ptr_nxt_o : pointer value to store once the refill installs; it only
//               moves when a valid line is being evicted
module icache_victim_sel
   import icache_pkg::*;
#(
   parameter int WAYS  = 2,
   parameter int WAY_W = way_w(WAYS)
) (
   input  logic [WAYS-1:0]  valid_i,
   input  logic [WAY_W-1:0] ptr_i,
   output logic [WAY_W-1:0] way_o,
   output logic [WAY_W-1:0] ptr_nxt_o
);

   logic evict;

   always_comb begin
      way_o = ptr_i;
      evict = 1'b1;
      // scan downwards so the lowest invalid way is the last one to win
      for (int w = WAYS - 1; w >= 0; w--) begin
         if (!valid_i[w]) begin
            way_o = WAY_W'(w);
            evict = 1'b0;
         end
      end
      if (WAYS == 1) way_o = '0;
      ptr_nxt_o = ptr_i;
      if (evict && WAYS > 1) ptr_nxt_o = ptr_i + 1'b1;
   end

endmodule

// File: rtl/icache_sa.sv
// Set-associative instruction cache between fetch and the line arbiter.
//   clk, reset    : clock, synchronous active-high reset
//   flush_i       : invalidate every line (wins over a same-cycle request)
//   bus           : icache_sa_if.slave, fetch and refill handshakes
//   hit_cnt_o     : saturating hit counter
//   miss_cnt_o    : saturating miss counter
// Hits answer one cycle after the request with no stall; a miss stalls,
// refills a whole line and answers one cycle after mem_ready.
module icache_sa
   import icache_pkg::*;
#(
   parameter int ADDR_W     = 32,
   parameter int LINE_BYTES = 16,
   parameter int SETS       = 4,
   parameter int WAYS       = 2,
   parameter int CNT_W      = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush_i,
   icache_sa_if.slave       bus,
   output logic [CNT_W-1:0] hit_cnt_o,
   output logic [CNT_W-1:0] miss_cnt_o
);

   localparam int OFF_W  = off_w(LINE_BYTES);
   localparam int IDX_W  = idx_w(SETS);
   localparam int TAG_W  = tag_w(ADDR_W, LINE_BYTES, SETS);
   localparam int WAY_W  = way_w(WAYS);
   localparam int WPL    = LINE_BYTES / 4;
   localparam int WS_W   = (WPL > 1) ? $clog2(WPL) : 1;
   localparam int LINE_W = LINE_BYTES * 8;

   typedef struct packed {
      logic [TAG_W-1:0] tag;
      logic [IDX_W-1:0] idx;
      logic [OFF_W-1:0] off;
   } addr_t;

   addr_t            a;
   logic [WS_W-1:0]  wsel;

   assign a    = bus.cpu_addr;
   assign wsel = WS_W'(a.off >> 2);   // byte-in-word bits are dropped here

   // line storage; only valid bits and pointers need a reset value
   logic [SETS-1:0][WAYS-1:0]  valid_q;
   logic [SETS-1:0][WAY_W-1:0] ptr_q;
   logic [TAG_W-1:0]           tags_q [SETS][WAYS];
   logic [LINE_W-1:0]          data_q [SETS][WAYS];

   logic [1:0]       state_q, state_d;
   logic [IDX_W-1:0] lat_idx_q;
   logic [TAG_W-1:0] lat_tag_q;
   logic [WS_W-1:0]  lat_ws_q;
   logic [WAY_W-1:0] vic_way_q, vic_ptr_q;
   logic             drop_q;
   logic             cvalid_q;
   logic [31:0]      rdata_q;
   logic [CNT_W-1:0] hit_cnt_q, miss_cnt_q;

   // lookup in the addressed set
   logic [WAYS-1:0]  match;
   logic [WAY_W-1:0] hit_way;
   logic             hit;
   logic [31:0]      hit_word;

   always_comb begin
      match   = '0;
      hit_way = '0;
      for (int w = 0; w < WAYS; w++) begin
         match[w] = valid_q[a.idx][w] && (tags_q[a.idx][w] == a.tag);
         if (match[w]) hit_way = WAY_W'(w);
      end
   end

   assign hit      = |match;
   assign hit_word = data_q[a.idx][hit_way][32*wsel +: 32];

   logic [WAY_W-1:0] vic_way, vic_ptr_nxt;

   icache_victim_sel #(.WAYS(WAYS), .WAY_W(WAY_W)) u_vsel (
      .valid_i   (valid_q[a.idx]),
      .ptr_i     (ptr_q[a.idx]),
      .way_o     (vic_way),
      .ptr_nxt_o (vic_ptr_nxt)
   );

   logic accept, do_hit, do_miss, install;

   assign accept  = (state_q == S_IDLE) && bus.cpu_req && !flush_i;
   assign do_hit  = accept && hit;
   assign do_miss = accept && !hit;
   // a flush seen at any point of the refill (now or earlier) discards the line
   assign install = (state_q == S_MISS) && bus.mem_ready && !drop_q && !flush_i;

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (do_miss) state_d = S_MISS;
         S_MISS:  if (bus.mem_ready) state_d = (drop_q || flush_i) ? S_IDLE : S_RESP;
         S_RESP:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S_IDLE;
         valid_q    <= '0;
         ptr_q      <= '0;
         lat_idx_q  <= '0;
         lat_tag_q  <= '0;
         lat_ws_q   <= '0;
         vic_way_q  <= '0;
         vic_ptr_q  <= '0;
         drop_q     <= 1'b0;
         cvalid_q   <= 1'b0;
         rdata_q    <= '0;
         hit_cnt_q  <= '0;
         miss_cnt_q <= '0;
      end else begin
         state_q  <= state_d;
         cvalid_q <= do_hit || install;
         if (do_hit)  rdata_q <= hit_word;
         if (install) rdata_q <= bus.mem_rdata[32*lat_ws_q +: 32];
         if (do_hit && ~&hit_cnt_q) hit_cnt_q <= hit_cnt_q + 1'b1;
         if (do_miss) begin
            lat_idx_q <= a.idx;
            lat_tag_q <= a.tag;
            lat_ws_q  <= wsel;
            vic_way_q <= vic_way;
            vic_ptr_q <= vic_ptr_nxt;
            if (~&miss_cnt_q) miss_cnt_q <= miss_cnt_q + 1'b1;
         end
         if (state_q == S_MISS) begin
            if (flush_i)       drop_q <= 1'b1;
            if (bus.mem_ready) drop_q <= 1'b0;
         end
         if (flush_i) begin
            valid_q <= '0;
         end else if (install) begin
            valid_q[lat_idx_q][vic_way_q] <= 1'b1;
            ptr_q[lat_idx_q]              <= vic_ptr_q;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset && install) begin
         tags_q[lat_idx_q][vic_way_q] <= lat_tag_q;
         data_q[lat_idx_q][vic_way_q] <= bus.mem_rdata;
      end
   end

   assign bus.cpu_valid = cvalid_q;
   assign bus.cpu_rdata = rdata_q;
   assign bus.cpu_stall = (state_q != S_IDLE) || (bus.cpu_req && (flush_i || !hit));
   assign bus.mem_req   = (state_q == S_MISS);
   assign bus.mem_addr  = {lat_tag_q, lat_idx_q};
   assign hit_cnt_o     = hit_cnt_q;
   assign miss_cnt_o    = miss_cnt_q;

endmodule

// File: tb/tb_icache_sa.sv
// Bench for icache_sa: directed scenarios followed by random fetch traffic,
// all checked against a line-level model of the cache contents.
module tb_icache_sa;

   localparam int ADDR_W = 32;
   localparam int LB     = 16;
   localparam int SETS   = 4;
   localparam int WAYS   = 2;
   localparam int CNT_W  = 4;
   localparam int LW     = LB * 8;
   localparam int CMAX   = (1 << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             reset;
   logic             flush;
   logic [CNT_W-1:0] hit_cnt, miss_cnt;

   icache_sa_if #(.ADDR_W(ADDR_W), .LINE_BYTES(LB)) bus ();

   icache_sa #(.ADDR_W(ADDR_W), .LINE_BYTES(LB), .SETS(SETS), .WAYS(WAYS), .CNT_W(CNT_W)) dut (
      .clk        (clk),
      .reset      (reset),
      .flush_i    (flush),
      .bus        (bus),
      .hit_cnt_o  (hit_cnt),
      .miss_cnt_o (miss_cnt)
   );

   always #5 clk = ~clk;

   // model: what each set holds, plus unsaturated event counts
   bit          m_v    [SETS][WAYS];
   int unsigned m_tag  [SETS][WAYS];
   logic [LW-1:0] m_line [SETS][WAYS];
   int          m_ptr  [SETS];
   int          m_hits, m_misses;

   int errs   = 0;
   int checks = 0;

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0h want %0h", tag, act, exp);
      end
   endtask

   function automatic int sat(input int x);
      return (x > CMAX) ? CMAX : x;
   endfunction

   function automatic logic [LW-1:0] rline();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   function automatic int m_find(input int s, input int unsigned t);
      for (int w = 0; w < WAYS; w++)
         if (m_v[s][w] && m_tag[s][w] == t) return w;
      return -1;
   endfunction

   function automatic int m_victim(input int s);
      for (int w = 0; w < WAYS; w++)
         if (!m_v[s][w]) return w;
      return m_ptr[s];
   endfunction

   task automatic m_flush();
      for (int s = 0; s < SETS; s++)
         for (int w = 0; w < WAYS; w++) m_v[s][w] = 1'b0;
   endtask

   task automatic check_cnts();
      chk("hit_cnt", hit_cnt, sat(m_hits));
      chk("miss_cnt", miss_cnt, sat(m_misses));
   endtask

   task automatic do_reset();
      reset = 1'b1; flush = 1'b0;
      bus.cpu_req = 1'b0; bus.cpu_addr = '0; bus.mem_ready = 1'b0; bus.mem_rdata = '0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      m_flush();
      for (int s = 0; s < SETS; s++) m_ptr[s] = 0;
      m_hits = 0; m_misses = 0;
      chk("rst_valid", bus.cpu_valid, 0);
      chk("rst_stall", bus.cpu_stall, 0);
      chk("rst_memreq", bus.mem_req, 0);
      chk("rst_memaddr", bus.mem_addr, 0);
      chk("rst_rdata", bus.cpu_rdata, 0);
      check_cnts();
   endtask

   // Starts and ends just after a negedge with the cache idle.
   // mode 0: plain, 1: flush while the refill is outstanding, 2: flush in the response cycle
   task automatic fetch(input int unsigned addr, input int mode, input logic [LW-1:0] fill);
      int s, w, way, waitc, flc;
      int unsigned t;
      bit evict;
      s = (addr / LB) % SETS;
      t = addr / (LB * SETS);
      w = (addr % LB) / 4;
      way = m_find(s, t);
      bus.cpu_req = 1'b1; bus.cpu_addr = addr;
      #1;
      if (way >= 0) begin
         chk("hit_stall", bus.cpu_stall, 0);
         @(posedge clk); m_hits++;
         @(negedge clk);
         chk("hit_valid", bus.cpu_valid, 1);
         chk("hit_rdata", bus.cpu_rdata, m_line[s][way][32*w +: 32]);
         chk("hit_memreq", bus.mem_req, 0);
         bus.cpu_req = 1'b0;
      end else begin
         chk("miss_stall", bus.cpu_stall, 1);
         way   = m_victim(s);
         evict = m_v[s][way];
         @(posedge clk); m_misses++;
         waitc = $urandom_range(0, 3);
         flc   = $urandom_range(0, waitc);
         for (int i = 0; i <= waitc; i++) begin
            @(negedge clk);
            chk("miss_memreq", bus.mem_req, 1);
            chk("miss_memaddr", bus.mem_addr, addr / LB);
            chk("miss_hold_stall", bus.cpu_stall, 1);
            chk("miss_novalid", bus.cpu_valid, 0);
            flush = (mode == 1 && i == flc);
            if (flush) m_flush();
            bus.mem_ready = (i == waitc);
            bus.mem_rdata = (i == waitc) ? fill : rline();
         end
         @(negedge clk);
         flush = 1'b0; bus.mem_ready = 1'b0; bus.mem_rdata = rline();
         if (mode == 1) begin
            chk("drop_novalid", bus.cpu_valid, 0);
            chk("drop_memreq", bus.mem_req, 0);
            bus.cpu_req = 1'b0;
         end else begin
            m_v[s][way] = 1'b1; m_tag[s][way] = t; m_line[s][way] = fill;
            if (evict) m_ptr[s] = (m_ptr[s] + 1) % WAYS;
            chk("refill_valid", bus.cpu_valid, 1);
            chk("refill_rdata", bus.cpu_rdata, fill[32*w +: 32]);
            chk("resp_stall", bus.cpu_stall, 1);
            chk("resp_memreq", bus.mem_req, 0);
            bus.cpu_req = 1'b0;
            if (mode == 2) begin flush = 1'b1; m_flush(); end
            @(negedge clk);
            flush = 1'b0;
            chk("after_resp_valid", bus.cpu_valid, 0);
         end
      end
      check_cnts();
   endtask

   // idle cycles with stray mem_ready pulses that must be ignored
   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         bus.cpu_req = 1'b0;
         bus.mem_ready = 1'($urandom_range(0, 1));
         bus.mem_rdata = rline();
         @(negedge clk);
         chk("idle_valid", bus.cpu_valid, 0);
         chk("idle_memreq", bus.mem_req, 0);
         chk("idle_stall", bus.cpu_stall, 0);
      end
      bus.mem_ready = 1'b0;
   endtask

   task automatic flush_idle(input int unsigned addr);
      bus.cpu_req = 1'b1; bus.cpu_addr = addr; flush = 1'b1;
      #1;
      chk("flush_stall", bus.cpu_stall, 1);
      @(posedge clk); m_flush();
      @(negedge clk);
      flush = 1'b0; bus.cpu_req = 1'b0;
      chk("flush_novalid", bus.cpu_valid, 0);
      chk("flush_memreq", bus.mem_req, 0);
      check_cnts();
   endtask

   initial begin
      int unsigned addr;
      int r;
      do_reset();

      // cold miss, then two back-to-back hits in the same line
      fetch(32'h100, 0, {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111});
      fetch(32'h108, 0, rline());
      fetch(32'h10C, 0, rline());
      idle(2);

      // two lines in set 0, then a third evicts the round-robin way
      do_reset();
      fetch(32'h000, 0, rline());
      fetch(32'h040, 0, rline());
      fetch(32'h000, 0, rline());
      fetch(32'h040, 0, rline());
      fetch(32'h080, 0, rline());
      fetch(32'h040, 0, rline());
      fetch(32'h000, 0, rline());

      // refill abandoned by a flush, then retried
      fetch(32'h200, 1, rline());
      fetch(32'h200, 0, rline());

      // flush beats a same-cycle request to a cached line
      fetch(32'h100, 0, rline());
      flush_idle(32'h100);
      fetch(32'h100, 0, rline());

      // hit counter saturation
      for (int i = 0; i < 20; i++) fetch(32'h104, 0, rline());
      idle(1);

      // flush arriving with the response
      fetch(32'h300, 2, rline());
      fetch(32'h300, 0, rline());

      // reset in the middle of a refill
      bus.cpu_req = 1'b1; bus.cpu_addr = 32'h3C0;
      @(negedge clk);
      chk("pre_rst_memreq", bus.mem_req, 1);
      do_reset();

      for (int n = 0; n < 400; n++) begin
         addr = $urandom_range(0, 5) * LB * SETS + $urandom_range(0, SETS - 1) * LB
              + $urandom_range(0, LB / 4 - 1) * 4 + $urandom_range(0, 3);
         r = $urandom_range(0, 99);
         if (r < 4) flush_idle(addr);
         r = $urandom_range(0, 99);
         fetch(addr, (r < 8) ? 1 : (r < 14) ? 2 : 0, rline());
         idle($urandom_range(0, 2));
      end

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
